// File: rtl/vga_pkg.sv
// vga_pkg -- shared definitions for the VGA timing generator.
//
// Holds the 640x480@60 timing constants, the generator FSM state type
// (IDLE, RUN), the per-axis region type (ACTIVE, FP, SYNC, BP) and a helper
// that classifies a coordinate into its region.
//
// Optional feature macro used by the design: VGA_FRAME_CNT_EN (frame counter).

package vga_pkg;

    // 640x480@60 Hz, 25 MHz pixel clock.
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    // Coordinates are 10 bits wide, so an axis may be at most 1024 long.
    localparam int unsigned AXIS_MAX_TOTAL = 1024;

    // Generator FSM. Kept as plain constants so the encoding is explicit.
    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t RUN  = 1'b1;

    // Region of one axis. The order matches the order along the axis.
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FP     = 2'd1,
        SYNC   = 2'd2,
        BP     = 2'd3
    } region_t;

    // Classify a coordinate; anything past active+fp+sync is back porch.
    function automatic logic [1:0] region_of(
        input logic [9:0]  coord,
        input logic [10:0] len_active,
        input logic [10:0] len_fp,
        input logic [10:0] len_sync
    );
        logic [10:0] c;
        c = {1'b0, coord};
        if (c < len_active) begin
            return ACTIVE;
        end else if (c < len_active + len_fp) begin
            return FP;
        end else if (c < len_active + len_fp + len_sync) begin
            return SYNC;
        end else begin
            return BP;
        end
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter -- one axis (horizontal or vertical) of the VGA raster.
//
// Counts 0 .. (active+fp+sync+bp)-1 on each tick and wraps to 0. Used twice
// by vga_timing: the horizontal instance ticks on every enabled pixel, the
// vertical instance ticks on the horizontal wrap.
//
// Ports:
//   clk_i         pixel clock (rising edge)
//   rst_i         synchronous active-high reset, count returns to 0
//   tick_i        advance the count by one
//   len_active_i  length of the visible region
//   len_fp_i      length of the front porch
//   len_sync_i    length of the sync pulse
//   len_bp_i      length of the back porch
//   count_o       current coordinate (registered)
//   region_o      region of count_o (a region_t value)
//   wrap_o        tick_i while count_o is the last coordinate of the axis

module vga_axis_counter
    import vga_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tick_i,
    input  logic [10:0] len_active_i,
    input  logic [10:0] len_fp_i,
    input  logic [10:0] len_sync_i,
    input  logic [10:0] len_bp_i,
    output logic [9:0]  count_o,
    output logic [1:0]  region_o,
    output logic        wrap_o
);

    logic [9:0]  count_q;
    logic [9:0]  count_d;
    logic [10:0] total;
    logic        last;

    assign total  = len_active_i + len_fp_i + len_sync_i + len_bp_i;
    assign last   = ({1'b0, count_q} == (total - 11'd1));
    assign wrap_o = tick_i && last;

    always_comb begin
        count_d = count_q;
        if (tick_i) begin
            count_d = last ? 10'd0 : (count_q + 10'd1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= 10'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign region_o = region_of(count_q, len_active_i, len_fp_i, len_sync_i);

endmodule

// File: rtl/vga_timing.sv
// vga_timing -- VGA raster timing generator (default 640x480@60).
//
// The two axis counters run one pixel ahead of the outputs: each enabled
// cycle the output registers capture the counters' pixel and its decodes,
// while the counters step to the following pixel. Every output is therefore
// a flop and all of them describe the same pixel in the same cycle.
//
// Ports:
//   clk_25        pixel clock, all logic on its rising edge
//   rst           synchronous active-high reset (dominates en)
//   en            pixel-advance enable; when low everything holds
//   sx, sy        current coordinate
//   hsync, vsync  sync outputs, asserted level H_POL / V_POL
//   active_pixel  (sx,sy) is in the visible area
//   line_start    high while sx==0
//   frame_start   high while sx==0 && sy==0
//   frame_cnt     frame index (only with `define VGA_FRAME_CNT_EN)
//
// Configuration macro: VGA_FRAME_CNT_EN adds the frame_cnt port/register.

module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter logic        H_POL    = 1'b0,
    parameter logic        V_POL    = 1'b0
) (
    input  logic        clk_25,
    input  logic        rst,
    input  logic        en,
    output logic [9:0]  sx,
    output logic [9:0]  sy,
    output logic        hsync,
    output logic        vsync,
    output logic        active_pixel,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Coordinates are 10 bits; longer axes cannot be represented.
    generate
        if (H_TOTAL > AXIS_MAX_TOTAL || H_TOTAL == 0) begin : g_bad_h_total
            $error("vga_timing: H_TOTAL=%0d must be 1..%0d", H_TOTAL, AXIS_MAX_TOTAL);
        end
        if (V_TOTAL > AXIS_MAX_TOTAL || V_TOTAL == 0) begin : g_bad_v_total
            $error("vga_timing: V_TOTAL=%0d must be 1..%0d", V_TOTAL, AXIS_MAX_TOTAL);
        end
    endgenerate

    localparam logic [10:0] H_ACTIVE_L = 11'(H_ACTIVE);
    localparam logic [10:0] H_FP_L     = 11'(H_FP);
    localparam logic [10:0] H_SYNC_L   = 11'(H_SYNC);
    localparam logic [10:0] H_BP_L     = 11'(H_BP);
    localparam logic [10:0] V_ACTIVE_L = 11'(V_ACTIVE);
    localparam logic [10:0] V_FP_L     = 11'(V_FP);
    localparam logic [10:0] V_SYNC_L   = 11'(V_SYNC);
    localparam logic [10:0] V_BP_L     = 11'(V_BP);

    // ------------------------------------------------------------------
    // Look-ahead pixel: the pixel the outputs will show on the next
    // enabled cycle.
    // ------------------------------------------------------------------
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic [1:0] h_region;
    logic [1:0] v_region;
    logic       h_wrap;
    logic       v_wrap;

    vga_axis_counter u_h_axis (
        .clk_i        (clk_25),
        .rst_i        (rst),
        .tick_i       (en),
        .len_active_i (H_ACTIVE_L),
        .len_fp_i     (H_FP_L),
        .len_sync_i   (H_SYNC_L),
        .len_bp_i     (H_BP_L),
        .count_o      (h_count),
        .region_o     (h_region),
        .wrap_o       (h_wrap)
    );

    vga_axis_counter u_v_axis (
        .clk_i        (clk_25),
        .rst_i        (rst),
        .tick_i       (h_wrap),
        .len_active_i (V_ACTIVE_L),
        .len_fp_i     (V_FP_L),
        .len_sync_i   (V_SYNC_L),
        .len_bp_i     (V_BP_L),
        .count_o      (v_count),
        .region_o     (v_region),
        .wrap_o       (v_wrap)
    );

    // The look-ahead pixel is (0,0) right after reset and right after the
    // vertical wrap; remembering that avoids a second 20-bit compare.
    logic origin_q;

    always_ff @(posedge clk_25) begin
        if (rst) begin
            origin_q <= 1'b1;
        end else if (en) begin
            origin_q <= v_wrap;
        end
    end

    // ------------------------------------------------------------------
    // FSM: IDLE until the first enabled cycle after reset, then RUN.
    // ------------------------------------------------------------------
    state_t state_q;
    state_t state_d;

    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk_25) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Output registers. With en low nothing is loaded, so strobes keep
    // their current value and downstream logic qualifies them with en.
    // ------------------------------------------------------------------
    logic [9:0] sx_q;
    logic [9:0] sy_q;
    logic       hsync_q;
    logic       vsync_q;
    logic       active_q;
    logic       line_start_q;
    logic       frame_start_q;

    always_ff @(posedge clk_25) begin
        if (rst) begin
            sx_q          <= 10'd0;
            sy_q          <= 10'd0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (en) begin
            sx_q          <= h_count;
            sy_q          <= v_count;
            hsync_q       <= (h_region == SYNC) ? H_POL : ~H_POL;
            vsync_q       <= (v_region == SYNC) ? V_POL : ~V_POL;
            active_q      <= (h_region == ACTIVE) && (v_region == ACTIVE);
            line_start_q  <= (h_count == 10'd0);
            frame_start_q <= origin_q;
        end
    end

    assign sx           = sx_q;
    assign sy           = sy_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign active_pixel = active_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
    // The frame shown on leaving IDLE is frame 0; every later frame start
    // counts up, wrapping naturally at 16 bits.
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk_25) begin
        if (rst) begin
            frame_cnt_q <= 16'd0;
        end else if (en && origin_q) begin
            frame_cnt_q <= (state_q == IDLE) ? 16'd0 : (frame_cnt_q + 16'd1);
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing -- directed bench for vga_timing.
//
// dut_f uses the default 640x480 timing for the per-line checks; dut_s uses
// a tiny raster (16x12 total) so whole frames, enable toggling, mid-frame
// reset and the frame counter can be exercised in a few thousand cycles.
// Both share clock, reset and enable; a coordinate model per instance gives
// the expected value of every output on every cycle.

module tb_vga_timing;

    // Small raster: H 8/2/3/3 (total 16), V 6/1/2/3 (total 12).
    localparam int S_HA = 8, S_HF = 2, S_HW = 3, S_HB = 3;
    localparam int S_VA = 6, S_VF = 1, S_VW = 2, S_VB = 3;
    localparam int S_HT = S_HA + S_HF + S_HW + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VW + S_VB;
    localparam int F_HA = 640, F_HF = 16, F_HW = 96, F_HT = 800;
    localparam int F_VA = 480, F_VF = 10, F_VW = 2, F_VT = 525;

    // ---------------- clock / reset ----------------
    logic clk_25 = 1'b0;
    logic rst    = 1'b1;
    logic en     = 1'b0;

    always #20 clk_25 = ~clk_25;

    logic [9:0] f_sx, f_sy, s_sx, s_sy;
    logic f_hs, f_vs, f_ap, f_ls, f_fs;
    logic s_hs, s_vs, s_ap, s_ls, s_fs;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] f_fc, s_fc;
`endif

    vga_timing dut_f (
        .clk_25       (clk_25),
        .rst          (rst),
        .en           (en),
        .sx           (f_sx),
        .sy           (f_sy),
        .hsync        (f_hs),
        .vsync        (f_vs),
        .active_pixel (f_ap),
        .line_start   (f_ls),
        .frame_start  (f_fs)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt    (f_fc)
`endif
    );

    vga_timing #(
        .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HW), .H_BP (S_HB),
        .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VW), .V_BP (S_VB)
    ) dut_s (
        .clk_25       (clk_25),
        .rst          (rst),
        .en           (en),
        .sx           (s_sx),
        .sy           (s_sy),
        .hsync        (s_hs),
        .vsync        (s_vs),
        .active_pixel (s_ap),
        .line_start   (s_ls),
        .frame_start  (s_fs)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt    (s_fc)
`endif
    );

    // ---------------- scoreboard state ----------------
    int vectors     = 0;
    int miscompares = 0;

    bit m_started = 1'b0;
    int fx = 0, fy = 0, f_fcm = 0;
    int sm_x = 0, sm_y = 0, s_fcm = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string who,
                                 input logic [9:0] o_sx, input logic [9:0] o_sy,
                                 input logic o_hs, input logic o_vs, input logic o_ap,
                                 input logic o_ls, input logic o_fs,
                                 input int x, input int y,
                                 input int ha, input int hf, input int hw,
                                 input int va, input int vf, input int vw);
        logic e_hs, e_vs, e_ap, e_ls, e_fs;
        if (!m_started) begin
            e_hs = 1'b1; e_vs = 1'b1; e_ap = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
        end else begin
            e_hs = (x >= ha + hf && x < ha + hf + hw) ? 1'b0 : 1'b1;
            e_vs = (y >= va + vf && y < va + vf + vw) ? 1'b0 : 1'b1;
            e_ap = (x < ha && y < va);
            e_ls = (x == 0);
            e_fs = (x == 0 && y == 0);
        end
        check({who, ".sx"}, 32'(o_sx), 32'(x));
        check({who, ".sy"}, 32'(o_sy), 32'(y));
        check({who, ".hsync"}, 32'(o_hs), 32'(e_hs));
        check({who, ".vsync"}, 32'(o_vs), 32'(e_vs));
        check({who, ".active_pixel"}, 32'(o_ap), 32'(e_ap));
        check({who, ".line_start"}, 32'(o_ls), 32'(e_ls));
        check({who, ".frame_start"}, 32'(o_fs), 32'(e_fs));
    endtask

    task automatic advance(inout int x, inout int y, input int ht, input int vt, inout int fc);
        if (x == ht - 1) begin
            x = 0;
            y = (y == vt - 1) ? 0 : y + 1;
        end else begin
            x = x + 1;
        end
        if (x == 0 && y == 0) fc = (fc + 1) % 65536;
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic rst_v, input logic en_v);
        rst = rst_v;
        en  = en_v;
        @(posedge clk_25);
        #1;
        if (rst_v) begin
            m_started = 1'b0;
            fx = 0; fy = 0; f_fcm = 0;
            sm_x = 0; sm_y = 0; s_fcm = 0;
        end else if (en_v) begin
            if (!m_started) begin
                m_started = 1'b1;
                fx = 0; fy = 0; f_fcm = 0;
                sm_x = 0; sm_y = 0; s_fcm = 0;
            end else begin
                advance(fx, fy, F_HT, F_VT, f_fcm);
                advance(sm_x, sm_y, S_HT, S_VT, s_fcm);
            end
        end
        check_outputs("full", f_sx, f_sy, f_hs, f_vs, f_ap, f_ls, f_fs,
                      fx, fy, F_HA, F_HF, F_HW, F_VA, F_VF, F_VW);
        check_outputs("small", s_sx, s_sy, s_hs, s_vs, s_ap, s_ls, s_fs,
                      sm_x, sm_y, S_HA, S_HF, S_HW, S_VA, S_VF, S_VW);
`ifdef VGA_FRAME_CNT_EN
        check("full.frame_cnt", 32'(f_fc), 32'(f_fcm));
        check("small.frame_cnt", 32'(s_fc), 32'(s_fcm));
`endif
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int hs_low, hs_first, hs_last, ls_cnt, vs_low, ap_cnt, vs_first_y, en_hi, guard;
        bit reached;

        // Reset for three cycles, then one idle cycle with en low.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("idle.frame_start", 32'(f_fs), 32'd0);

        // One full 800-pixel line plus the first pixel of the next line.
        hs_low = 0; hs_first = -1; hs_last = -1; ls_cnt = 0;
        for (int i = 0; i <= 800; i++) begin
            step(1'b0, 1'b1);
            if (i == 0) begin
                check("first.sx", 32'(f_sx), 32'd0);
                check("first.sy", 32'(f_sy), 32'd0);
                check("first.frame_start", 32'(f_fs), 32'd1);
                check("first.active_pixel", 32'(f_ap), 32'd1);
                check("first.hsync", 32'(f_hs), 32'd1);
                check("first.vsync", 32'(f_vs), 32'd1);
            end
            if (i == 800) begin
                check("line2.line_start", 32'(f_ls), 32'd1);
                check("line2.sy", 32'(f_sy), 32'd1);
            end
            if (f_hs == 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(f_sx);
                hs_last = int'(f_sx);
            end
            if (f_ls) ls_cnt++;
        end
        check("line.hsync_low_cycles", 32'(hs_low), 32'd96);
        check("line.hsync_first_x", 32'(hs_first), 32'd656);
        check("line.hsync_last_x", 32'(hs_last), 32'd751);
        check("line.line_start_pulses", 32'(ls_cnt), 32'd2);

        // One whole small frame from reset.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        vs_low = 0; ap_cnt = 0; vs_first_y = -1;
        for (int i = 0; i < S_HT * S_VT; i++) begin
            step(1'b0, 1'b1);
            if (s_vs == 1'b0) begin
                vs_low++;
                if (vs_first_y < 0) vs_first_y = int'(s_sy);
            end
            if (s_ap) ap_cnt++;
            if (i == S_HT * S_VT - 1) begin
                check("frame.last_sx", 32'(s_sx), 32'd15);
                check("frame.last_sy", 32'(s_sy), 32'd11);
            end
        end
        check("frame.vsync_low_cycles", 32'(vs_low), 32'd32);
        check("frame.vsync_first_sy", 32'(vs_first_y), 32'd7);
        check("frame.active_cycles", 32'(ap_cnt), 32'd48);
        step(1'b0, 1'b1);
        check("frame2.sx", 32'(s_sx), 32'd0);
        check("frame2.sy", 32'(s_sy), 32'd0);
        check("frame2.frame_start", 32'(s_fs), 32'd1);

        // Random enable at ~50% over two small frames of enabled pixels.
        en_hi = 0; guard = 0;
        while (en_hi < 2 * S_HT * S_VT && guard < 4000) begin
            logic e;
            e = logic'($urandom_range(0, 1));
            step(1'b0, e);
            if (e) en_hi++;
            guard++;
        end
        check("random.enabled_cycles", 32'(en_hi), 32'(2 * S_HT * S_VT));

        // Mid-frame reset at small-raster pixel (10,5), with en held high.
        reached = 1'b0; guard = 0;
        while (!reached && guard < 500) begin
            step(1'b0, 1'b1);
            reached = (s_sx == 10'd10 && s_sy == 10'd5);
            guard++;
        end
        check("midreset.reached_10_5", 32'(reached), 32'd1);
        step(1'b1, 1'b1);
        check("midreset.sx", 32'(s_sx), 32'd0);
        check("midreset.sy", 32'(s_sy), 32'd0);
        check("midreset.hsync", 32'(s_hs), 32'd1);
        check("midreset.active_pixel", 32'(s_ap), 32'd0);
        check("midreset.frame_start", 32'(s_fs), 32'd0);
        check("midreset.full_sx", 32'(f_sx), 32'd0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check("release.sx", 32'(s_sx), 32'd0);
        check("release.sy", 32'(s_sy), 32'd0);
        check("release.frame_start", 32'(s_fs), 32'd1);
        check("release.active_pixel", 32'(s_ap), 32'd1);

`ifdef VGA_FRAME_CNT_EN
        begin
            int k;
            check("fc.frame0", 32'(s_fc), 32'd0);
            k = 1;
            for (int i = 0; i < 2 * S_HT * S_VT; i++) begin
                step(1'b0, 1'b1);
                if (s_fs) begin
                    check("fc.frame_n", 32'(s_fc), 32'(k));
                    k++;
                end
            end
            check("fc.frame_starts_seen", 32'(k), 32'd3);

            force dut_s.frame_cnt_q = 16'hffff;
            s_fcm = 65535;
            step(1'b0, 1'b0);
            release dut_s.frame_cnt_q;
            step(1'b0, 1'b0);
            guard = 0;
            reached = 1'b0;
            while (!reached && guard < 400) begin
                step(1'b0, 1'b1);
                reached = s_fs;
                guard++;
            end
            check("fc.wrap_seen", 32'(reached), 32'd1);
            check("fc.wrap_value", 32'(s_fc), 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameters SHALL be: H_ACTIVE 640 visible pixels; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch; V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33; H_POL 0 hsync asserted level; V_POL 0 vsync asserted level.
REQ-002 clk_25  input  1  pixel clock; the block has one clock and all logic is on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 en  input  1  pixel-advance enable; when low, all state and outputs hold.
REQ-005 sx  output  10  current horizontal coordinate.
REQ-006 sy  output  10  current vertical coordinate.
REQ-007 hsync  output  1  horizontal sync.
REQ-008 vsync  output  1  vertical sync.
REQ-009 active_pixel  output  1  high when (sx,sy) is in the visible area.
REQ-010 line_start  output  1  one-pixel strobe at sx==0.
REQ-011 frame_start  output  1  one-pixel strobe at sx==0 && sy==0.
REQ-012 frame_cnt  output  16  frame index; the port exists only with VGA_FRAME_CNT_EN.

Function
REQ-013 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800) and V_TOTAL (default 525) SHALL each be ≤1024; an elaboration-time check SHALL reject violations.
REQ-014 FSM SHALL have two states: IDLE (entered on reset) and RUN.
REQ-015 IDLE: the first cycle with en=1 SHALL move to RUN and present (0,0) with line_start=1, frame_start=1, active_pixel=1.
REQ-016 RUN, en=1: sx SHALL increment; sx==H_TOTAL-1 SHALL wrap to 0 and increment sy; (H_TOTAL-1, V_TOTAL-1) SHALL wrap to (0,0).
REQ-017 Horizontal regions: active 0..639, FP 640..655, sync 656..751, BP 752..799. Vertical regions: active 0..479, FP 480..489, sync 490..491, BP 492..524.
REQ-018 hsync SHALL be at level H_POL for sx in the sync region and at ~H_POL otherwise.
REQ-019 vsync SHALL be at level V_POL for every pixel of sy 490..491 and at ~V_POL otherwise.
REQ-020 All outputs SHALL be registered and SHALL describe the same pixel in the same cycle; there is zero skew between coordinates and decodes.
REQ-021 active_pixel SHALL equal (sx<H_ACTIVE && sy<V_ACTIVE).
REQ-022 en=0 SHALL freeze all outputs; strobes SHALL remain at their current value. Downstream logic qualifies strobes with en.
REQ-023 The last pixel of each frame SHALL be (799,524); downstream per-frame updates keyed on sy==V_TOTAL-1 SHALL see sx==0 of that line exactly once per frame.

Reset
REQ-024 While rst=1: state=IDLE, sx=0, sy=0, active_pixel=0, line_start=0, frame_start=0, hsync=~H_POL, vsync=~V_POL, frame_cnt=0.
REQ-025 rst SHALL dominate en, and an assertion mid-frame SHALL return to IDLE at the next edge.

Configuration
REQ-026 With VGA_FRAME_CNT_EN defined, frame_cnt SHALL be 0 at the first frame_start after reset, increment coincident with each later frame_start, and wrap from 65535 to 0.
REQ-027 Without VGA_FRAME_CNT_EN, the frame_cnt port and its register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Package vga_pkg SHALL hold the 640x480@60 timing constants, the FSM state typedef (IDLE, RUN) and the region typedef (ACTIVE, FP, SYNC, BP).
REQ-029 Sub-module vga_axis_counter SHALL be instantiated twice (horizontal, vertical), with inputs tick and four region lengths and outputs count, region and wrap; the vertical tick is the horizontal wrap.

Verification
REQ-030 rst for 3 cycles, then en=1 → first output (0,0) with frame_start=1, active_pixel=1, hsync=1, vsync=1.
REQ-031 Run 1 line → hsync=0 exactly for sx 656..751 (96 cycles); line_start pulses at cycles 0 and 800.
REQ-032 Run 1 frame (420000 cycles) → vsync=0 for 1600 cycles on sy 490..491; active_pixel high for 307200 cycles; next pixel is (0,0) with frame_start.
REQ-033 Toggle en at random with a 50% duty cycle over 2 frames → output sequence identical to the en=1 run with hold cycles removed.
REQ-034 Assert rst at (300,200) → next cycle all outputs at reset values; the first en cycle after release presents (0,0).
REQ-035 With VGA_FRAME_CNT_EN, run 3 frames → frame_cnt reads 0, 1, 2 at successive frame_starts; preload 65535 by force → next frame_start reads 0.
